// File: rtl/pushbutton_pkg.sv
// pushbutton_pkg: shared constants, FSM state type and index helpers for
// the push-button / LED arbiter.
//   NUM_BUTTONS     number of buttons and LEDs
//   LED_RESET       display pattern after reset
//   state_t         ROTATE (free-running pattern) / OWNED (button shown)
//   index_to_onehot 3-bit index -> 8-bit one-hot LED pattern
//   first_set_from  first set bit of a vector, scanning up from a start
//                   index and wrapping (priority / round-robin search)
package pushbutton_pkg;

  localparam int         NUM_BUTTONS = 8;
  localparam logic [7:0] LED_RESET   = 8'h01;

  typedef enum logic {
    ROTATE = 1'b0,
    OWNED  = 1'b1
  } state_t;

  function automatic logic [7:0] index_to_onehot(input logic [2:0] idx);
    index_to_onehot = 8'(1) << idx;
  endfunction

  // Start index 0 gives plain lowest-index-wins priority.
  function automatic logic [2:0] first_set_from(input logic [7:0] vec,
                                                input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    first_set_from = start;
    found          = 1'b0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      idx = start + 3'(k);
      if (!found && vec[idx]) begin
        first_set_from = idx;
        found          = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pushbutton_led_arbiter_button_debouncer.sv
// button_debouncer: two-flop synchroniser, tick-sampled debounce and press
// event generation for eight active-low buttons.
//   clk, rst_n   clock, asynchronous active-low reset
//   raw_n[7:0]   raw button pins, 0 = pressed, asynchronous to clk
//   deb_state    debounced button level (0 = pressed)
//   press_pulse  one-cycle pulse per debounced 1->0 transition
// A bit's debounced level only changes when two consecutive samples
// (taken every DEBOUNCE_CYCLES) agree. A button only produces presses once
// it has been seen released since reset, so a button held through reset
// must be released and pressed again before it counts.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] raw_n,
  output logic [7:0] deb_state,
  output logic [7:0] press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] deb_cnt;
  logic          deb_tick;
  logic [7:0]    sync1, sync2;
  logic [7:0]    sample_q;
  logic [7:0]    deb_q, deb_prev_q;
  logic [7:0]    armed_q;
  logic [7:0]    agree;

  assign deb_tick  = (deb_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign agree     = ~(sync2 ^ sample_q);
  assign deb_state = deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '1;
      sync2       <= '1;
      deb_cnt     <= '0;
      sample_q    <= '1;
      deb_q       <= '1;
      deb_prev_q  <= '1;
      armed_q     <= '0;
      press_pulse <= '0;
    end else begin
      sync1   <= raw_n;
      sync2   <= sync1;
      deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
      if (deb_tick) begin
        sample_q <= sync2;
        deb_q    <= (agree & sync2) | (~agree & deb_q);
        // A confirmed release arms the button for later presses.
        armed_q  <= armed_q | (agree & sync2);
      end
      deb_prev_q  <= deb_q;
      press_pulse <= deb_prev_q & ~deb_q & armed_q;
    end
  end

endmodule

// File: rtl/pushbutton_led_arbiter.sv
// pushbutton_led_arbiter: shares an 8-LED one-hot display between a
// rotating pattern and eight debounced active-low push buttons.
//   Clk, Rst_n   clock, asynchronous active-low reset
//   Switch[7:0]  raw button pins, 0 = pressed
//   LED[7:0]     display, always one-hot
//   Owner[2:0]   current or most recent owning button
//   Owner_valid  1 while a button owns the display
//   Press_pulse  one-cycle debounced press events
//   state_dbg    FSM state (0 = ROTATE, 1 = OWNED) for observation
// Build option ROUND_ROBIN_EN: simultaneous presses are granted round-robin
// starting after the last granted index; otherwise lowest index wins.
// No valid/ready handshakes exist here: Press_pulse is a plain event strobe
// that is consumed in the cycle it is high and never back-pressured.
module pushbutton_led_arbiter
  import pushbutton_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned STEP_CYCLES     = 16_777_216,
  parameter int unsigned HOLD_STEPS      = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Switch,
  output logic [7:0] LED,
  output logic [2:0] Owner,
  output logic       Owner_valid,
  output logic [7:0] Press_pulse,
  output logic       state_dbg
);

  localparam int         SW        = $clog2(STEP_CYCLES);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_STEPS);

  logic [7:0]    deb_state;
  logic [SW-1:0] step_cnt;
  logic          step_tick;
  logic          press_any;
  logic [2:0]    winner;

  state_t        state_q, state_d;
  logic [7:0]    led_q, led_d;
  logic [2:0]    owner_q, owner_d;
  logic [7:0]    hold_q, hold_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .raw_n      (Switch),
    .deb_state  (deb_state),
    .press_pulse(Press_pulse)
  );

  // Step counter free-runs; button activity never restarts it.
  assign step_tick = (step_cnt == SW'(STEP_CYCLES - 1));
  assign press_any = |Press_pulse;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  assign winner = first_set_from(Press_pulse, ptr_q + 3'd1);
`else
  assign winner = first_set_from(Press_pulse, 3'd0);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      step_cnt <= '0;
      state_q  <= ROTATE;
      led_q    <= LED_RESET;
      owner_q  <= 3'd0;
      hold_q   <= 8'd0;
`ifdef ROUND_ROBIN_EN
      ptr_q    <= 3'd7;
`endif
    end else begin
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      state_q  <= state_d;
      led_q    <= led_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
`ifdef ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // A press always takes priority over rotation and hold expiry.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    owner_d = owner_q;
    hold_d  = hold_q;
`ifdef ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    if (press_any) begin
      state_d = OWNED;
      owner_d = winner;
      led_d   = index_to_onehot(winner);
      hold_d  = HOLD_LOAD;
`ifdef ROUND_ROBIN_EN
      ptr_d   = winner;
`endif
    end else begin
      case (state_q)
        OWNED: begin
          if (!deb_state[owner_q]) begin
            hold_d = HOLD_LOAD;
          end else if (step_tick) begin
            if (hold_q <= 8'd1) begin
              hold_d  = 8'd0;
              state_d = ROTATE;
            end else begin
              hold_d = hold_q - 8'd1;
            end
          end
        end
        default: begin
          if (step_tick) led_d = {led_q[0], led_q[7:1]};
        end
      endcase
    end
  end

  assign LED         = led_q;
  assign Owner       = owner_q;
  assign Owner_valid = (state_q == OWNED);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pushbutton_led_arbiter.sv
// tb_pushbutton_led_arbiter: directed scenarios plus randomized button
// traffic, every cycle compared against a reference model that works in
// terms of sample history, tick numbers and an LED position index.
module tb_pushbutton_led_arbiter;

  localparam int DEB  = 4;
  localparam int STEP = 8;
  localparam int HOLD = 3;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] Switch = 8'hFF;
  logic [7:0] LED;
  logic [2:0] Owner;
  logic       Owner_valid;
  logic [7:0] Press_pulse;
  logic       state_dbg;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  pushbutton_led_arbiter #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES    (STEP),
    .HOLD_STEPS     (HOLD)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Switch     (Switch),
    .LED        (LED),
    .Owner      (Owner),
    .Owner_valid(Owner_valid),
    .Press_pulse(Press_pulse),
    .state_dbg  (state_dbg)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] hist[$];      // Switch value seen at each posedge since reset
  int         k;            // posedges since reset release
  logic [7:0] last_sample;  // previous debounce sample
  logic [7:0] m_deb;        // debounced level
  logic [7:0] m_armed;      // seen released since reset
  logic [7:0] m_pend;       // press events due on the next edge
  logic [7:0] m_pulse;
  int         m_led_pos, m_owner, m_hold, m_ptr;
  bit         m_owned;

  task automatic model_reset();
    hist.delete();
    k = 0;
    last_sample = 8'hFF;
    m_deb = 8'hFF;
    m_armed = 8'h00;
    m_pend = 8'h00;
    m_pulse = 8'h00;
    m_led_pos = 0;
    m_owner = 0;
    m_hold = 0;
    m_ptr = 7;
    m_owned = 0;
  endtask

  function automatic int pick(input logic [7:0] ev, input int ptr);
    int start;
`ifdef ROUND_ROBIN_EN
    start = (ptr + 1) % 8;
`else
    start = 0;
`endif
    for (int j = 0; j < 8; j++)
      if (ev[(start + j) % 8]) return (start + j) % 8;
    return 0;
  endfunction

  // One posedge worth of behaviour, using values from before the edge.
  task automatic model_step(input logic [7:0] sw);
    logic [7:0] cur, agree, new_deb;
    int w;
    hist.push_back(sw);
    if (m_pulse != 8'h00) begin
      w = pick(m_pulse, m_ptr);
      m_owner = w; m_led_pos = w; m_owned = 1; m_hold = HOLD; m_ptr = w;
    end else if (m_owned) begin
      if (!m_deb[m_owner]) m_hold = HOLD;
      else if (k % STEP == STEP - 1) begin
        m_hold--;
        if (m_hold == 0) m_owned = 0;
      end
    end else if (k % STEP == STEP - 1) begin
      m_led_pos = (m_led_pos + 7) % 8;
    end
    m_pulse = m_pend;
    m_pend = 8'h00;
    if (k % DEB == DEB - 1) begin
      cur = (k >= 2) ? hist[k - 2] : 8'hFF;  // two-flop synchroniser delay
      agree = ~(cur ^ last_sample);
      new_deb = (agree & cur) | (~agree & m_deb);
      m_pend = m_deb & ~new_deb & m_armed;
      m_armed = m_armed | (agree & cur);
      m_deb = new_deb;
      last_sample = cur;
    end
    exp_q.push_back(m_pulse);
    k++;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [7:0] sw);
    Switch = sw;
    @(posedge Clk);
    model_step(sw);
    @(negedge Clk);
    check_eq("led", LED, 8'(1) << m_led_pos);
    check_eq("led_onehot", 8'($onehot(LED)), 8'd1);
    check_eq("owner", 8'(Owner), 8'(m_owner));
    check_eq("owner_valid", 8'(Owner_valid), 8'(m_owned));
    check_eq("press_pulse", Press_pulse, exp_q.pop_front());
  endtask

  task automatic check_reset_values();
    check_eq("rst_led", LED, 8'h01);
    check_eq("rst_owner", 8'(Owner), 8'h00);
    check_eq("rst_owner_valid", 8'(Owner_valid), 8'h00);
    check_eq("rst_press_pulse", Press_pulse, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    int len;
    Rst_n = 1'b0;
    Switch = 8'hFF;
    #12;
    check_reset_values();
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;

    // idle rotation
    repeat (40) cycle(8'hFF);

    // bounce on button 2, then a clean hold
    for (int i = 0; i < 20; i++) cycle(((i / 3) % 2 == 0) ? 8'hFB : 8'hFF);
    repeat (20) cycle(8'hFB);
    repeat (40) cycle(8'hFF);

    // long hold on button 5, release, let the hold expire and rotate
    repeat (100) cycle(8'hDF);
    repeat (60) cycle(8'hFF);

    // simultaneous press of buttons 1, 4, 6
    repeat (20) cycle(8'hAD);
    repeat (50) cycle(8'hFF);

    // button 3 owns, button 7 preempts
    repeat (20) cycle(8'hF7);
    repeat (20) cycle(8'h77);
    repeat (50) cycle(8'hFF);

    // reset while button 6 owns and is still held
    repeat (20) cycle(8'hBF);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1 check_reset_values();
    model_reset();
    exp_q.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (40) cycle(8'hBF);
    repeat (20) cycle(8'hFF);
    repeat (20) cycle(8'hBF);
    repeat (30) cycle(8'hFF);

    // randomized traffic
    repeat (150) begin
      case ($urandom_range(0, 3))
        0: v = 8'hFF;
        1: v = ~(8'(1) << $urandom_range(0, 7));
        2: v = 8'($urandom) | 8'($urandom);
        default: v = 8'($urandom);
      endcase
      len = $urandom_range(1, 25);
      repeat (len) cycle(v);
    end
    repeat (40) cycle(8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
